// File: rtl/mem_seq_pkg.sv
// Shared memory-access definitions: op encodings, request payload and auto-index decode.
package mem_seq_pkg;

  localparam int unsigned FIELD_W = 3;
  localparam int unsigned WADDR_W = 12;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_ISZ   = 2'd2,
    OP_IND   = 2'd3
  } op_e;

  // Auto-index locations 0010-0017 share this value on addr[11:3]
  localparam logic [8:0] AUTO_IDX_WIN = 9'o001;

  typedef struct packed {
    op_e                op;
    logic [FIELD_W-1:0] field;
    logic [WADDR_W-1:0] addr;
  } mem_req_t;

  function automatic logic is_auto_idx(input logic [WADDR_W-1:0] a);
    return a[11:3] == AUTO_IDX_WIN;
  endfunction

endpackage

// File: rtl/mem_seq.sv
// Memory-cycle sequencer: turns single CPU requests into read, write or
// read-modify-write cycles on a memory port with one-cycle registered read latency.
module mem_seq
  import mem_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req,
  input  logic [1:0]         op,
  input  logic [FIELD_W-1:0] field,
  input  logic [WADDR_W-1:0] addr,
  input  logic [DATA_W-1:0]  wdata,
  output logic               ready,
  output logic               done,
  output logic [DATA_W-1:0]  rdata,
  output logic               skip,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_din,
  output logic               mem_we,
  input  logic [DATA_W-1:0]  mem_dout
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  state_e              r_state;
  state_e              w_next;
  mem_req_t            r_req;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_skip;
  logic [DATA_W-1:0]   w_inc;
  logic                w_wb;
  logic                w_accept;

  assign w_accept = (r_state == ST_IDLE) && req;
  assign w_inc    = mem_dout + DATA_W'(1);
  // Captured word is written back incremented for ISZ and auto-index IND
  assign w_wb     = (r_req.op == OP_ISZ) ||
                    ((r_req.op == OP_IND) && is_auto_idx(r_req.addr));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req) begin
          w_next = (op_e'(op) == OP_WRITE) ? ST_WR : ST_RD;
        end
      end
      ST_RD:   w_next = ST_CAP;
      ST_CAP:  w_next = w_wb ? ST_WR : ST_DONE;
      ST_WR:   w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_req   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_skip  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_req   <= mem_req_t'{op: op_e'(op), field: field, addr: addr};
        r_wdata <= wdata;
        r_skip  <= 1'b0;
      end
      if (r_state == ST_CAP) begin
        r_rdata <= w_wb ? w_inc : mem_dout;
        r_skip  <= (r_req.op == OP_ISZ) && (w_inc == '0);
      end
    end
  end

  assign ready    = (r_state == ST_IDLE);
  assign done     = (r_state == ST_DONE);
  assign rdata    = r_rdata;
  assign skip     = r_skip;
  assign mem_addr = ADDR_W'({r_req.field, r_req.addr});
  assign mem_din  = (r_req.op == OP_WRITE) ? r_wdata : r_rdata;
  // Gate with reset so no write escapes in a reset cycle
  assign mem_we   = (r_state == ST_WR) && !reset;

endmodule

// File: tb/tb_mem_seq.sv
// Bench for mem_seq against a behavioural memory array (fields 0-3 populated,
// one-cycle registered read, out-of-range reads return 0000).
module tb_mem_seq;

  localparam int unsigned MEM_WORDS = 16384;
  localparam logic [1:0] T_READ  = 2'd0;
  localparam logic [1:0] T_WRITE = 2'd1;
  localparam logic [1:0] T_ISZ   = 2'd2;
  localparam logic [1:0] T_IND   = 2'd3;

  logic        clk;
  logic        reset;
  logic        req;
  logic [1:0]  op;
  logic [2:0]  field;
  logic [11:0] addr;
  logic [11:0] wdata;
  logic        ready;
  logic        done;
  logic [11:0] rdata;
  logic        skip;
  logic [14:0] mem_addr;
  logic [11:0] mem_din;
  logic        mem_we;
  logic [11:0] mem_dout;

  logic [11:0] mem [0:MEM_WORDS-1];

  typedef struct {
    logic        chk_rd;
    logic [11:0] rd;
    logic        sk;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [11:0] rd;
  logic        sk;
  int          lat;
  int          n_checks;
  int          n_pass;

  mem_seq dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .op       (op),
    .field    (field),
    .addr     (addr),
    .wdata    (wdata),
    .ready    (ready),
    .done     (done),
    .rdata    (rdata),
    .skip     (skip),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_we   (mem_we),
    .mem_dout (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we && !mem_addr[14]) mem[mem_addr[13:0]] <= mem_din;
    mem_dout <= mem_addr[14] ? 12'o0000 : mem[mem_addr[13:0]];
  end

  // Issue one request and report what the DUT produced at its done pulse (lat=0: none)
  task automatic run_op(input logic [1:0] o, input logic [2:0] f, input logic [11:0] a,
                        input logic [11:0] wd, output logic [11:0] got_rd,
                        output logic got_sk, output int got_lat);
    int w;
    got_rd = '0;
    got_sk = 1'b0;
    got_lat = 0;
    w = 0;
    @(negedge clk);
    while (!ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    req = 1'b1; op = o; field = f; addr = a; wdata = wd;
    @(posedge clk);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      req = 1'b0;
      if (done) begin
        got_lat = i; got_rd = rdata; got_sk = skip;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", ready); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else n_pass++;
    n_checks++; if (skip !== 1'b0) $display("FAIL rst_skip: got %b want 0", skip); else n_pass++;
    n_checks++; if (rdata !== 12'o0000) $display("FAIL rst_rdata: got %o want 0", rdata); else n_pass++;
    n_checks++; if (mem_we !== 1'b0) $display("FAIL rst_we: got %b want 0", mem_we); else n_pass++;
    n_checks++; if (mem_addr !== 15'd0) $display("FAIL rst_addr: got %o want 0", mem_addr); else n_pass++;
    n_checks++; if (mem_din !== 12'o0000) $display("FAIL rst_din: got %o want 0", mem_din); else n_pass++;
  endtask

  task automatic test_write_read();
    exp_q.push_back('{1'b0, 12'o0000, 1'b0, 2});
    run_op(T_WRITE, 3'd2, 12'o0123, 12'o4567, rd, sk, lat);
    e = exp_q.pop_front();
    n_checks++;
    if ({(e.chk_rd ? rd : e.rd), sk, lat} !== {e.rd, e.sk, e.lat})
      $display("FAIL write: got rdata=%o skip=%b lat=%0d want rdata=%o skip=%b lat=%0d", rd, sk, lat, e.rd, e.sk, e.lat);
    else n_pass++;
    n_checks++; if (mem[{3'd2, 12'o0123}] !== 12'o4567) $display("FAIL write_mem: got %o want 4567", mem[{3'd2, 12'o0123}]); else n_pass++;
    exp_q.push_back('{1'b1, 12'o4567, 1'b0, 3});
    run_op(T_READ, 3'd2, 12'o0123, 12'o0000, rd, sk, lat);
    e = exp_q.pop_front();
    n_checks++;
    if ({(e.chk_rd ? rd : e.rd), sk, lat} !== {e.rd, e.sk, e.lat})
      $display("FAIL read: got rdata=%o skip=%b lat=%0d want rdata=%o skip=%b lat=%0d", rd, sk, lat, e.rd, e.sk, e.lat);
    else n_pass++;
  endtask

  task automatic test_isz();
    logic [11:0] model;
    model = 12'o7776;
    run_op(T_WRITE, 3'd1, 12'o0200, model, rd, sk, lat);
    for (int k = 0; k < 2; k++) begin
      model = model + 12'o0001;
      exp_q.push_back('{1'b1, model, (model == 12'o0000), 4});
      run_op(T_ISZ, 3'd1, 12'o0200, 12'o0000, rd, sk, lat);
      e = exp_q.pop_front();
      n_checks++;
      if ({(e.chk_rd ? rd : e.rd), sk, lat} !== {e.rd, e.sk, e.lat})
        $display("FAIL isz%0d: got rdata=%o skip=%b lat=%0d want rdata=%o skip=%b lat=%0d", k, rd, sk, lat, e.rd, e.sk, e.lat);
      else n_pass++;
      n_checks++; if (mem[{3'd1, 12'o0200}] !== model) $display("FAIL isz%0d_mem: got %o want %o", k, mem[{3'd1, 12'o0200}], model); else n_pass++;
    end
  endtask

  task automatic test_ind();
    logic [11:0] ptrs [2];
    logic [11:0] want [2];
    int          lats [2];
    ptrs[0] = 12'o0012; want[0] = 12'o0400; lats[0] = 4;
    ptrs[1] = 12'o0020; want[1] = 12'o0377; lats[1] = 3;
    for (int k = 0; k < 2; k++) begin
      run_op(T_WRITE, 3'd0, ptrs[k], 12'o0377, rd, sk, lat);
      exp_q.push_back('{1'b1, want[k], 1'b0, lats[k]});
      run_op(T_IND, 3'd0, ptrs[k], 12'o0000, rd, sk, lat);
      e = exp_q.pop_front();
      n_checks++;
      if ({(e.chk_rd ? rd : e.rd), sk, lat} !== {e.rd, e.sk, e.lat})
        $display("FAIL ind%0d: got rdata=%o skip=%b lat=%0d want rdata=%o skip=%b lat=%0d", k, rd, sk, lat, e.rd, e.sk, e.lat);
      else n_pass++;
      n_checks++; if (mem[{3'd0, ptrs[k]}] !== want[k]) $display("FAIL ind%0d_mem: got %o want %o", k, mem[{3'd0, ptrs[k]}], want[k]); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int acc, dn, we, bad;
    acc = 0; dn = 0; we = 0; bad = 0;
    @(negedge clk);
    req = 1'b1; field = 3'd2; addr = 12'o0123; wdata = 12'o7070;
    for (int i = 0; i < 16; i++) begin
      // Offer a WRITE whenever the sequencer is busy; it must never be taken
      op = ready ? T_READ : T_WRITE;
      if (ready) acc++;
      @(negedge clk);
      if (done) begin
        dn++;
        if (rdata !== 12'o4567) bad++;
      end
      if (mem_we) we++;
    end
    req = 1'b0;
    n_checks++; if (acc !== 4) $display("FAIL b2b_accepts: got %0d want 4", acc); else n_pass++;
    n_checks++; if (dn !== 4) $display("FAIL b2b_dones: got %0d want 4", dn); else n_pass++;
    n_checks++; if (we !== 0) $display("FAIL b2b_writes: got %0d want 0", we); else n_pass++;
    n_checks++; if (bad !== 0) $display("FAIL b2b_rdata: got %0d bad want 0", bad); else n_pass++;
  endtask

  task automatic test_reset_mid_op();
    run_op(T_WRITE, 3'd1, 12'o0300, 12'o0005, rd, sk, lat);
    @(negedge clk);
    req = 1'b1; op = T_ISZ; field = 3'd1; addr = 12'o0300;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (ready !== 1'b1) $display("FAIL cap_rst_ready: got %b want 1", ready); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL cap_rst_done: got %b want 0", done); else n_pass++;
    n_checks++; if (skip !== 1'b0) $display("FAIL cap_rst_skip: got %b want 0", skip); else n_pass++;
    n_checks++; if (rdata !== 12'o0000) $display("FAIL cap_rst_rdata: got %o want 0", rdata); else n_pass++;
    n_checks++; if (mem_we !== 1'b0) $display("FAIL cap_rst_we: got %b want 0", mem_we); else n_pass++;
    n_checks++; if (mem_addr !== 15'd0) $display("FAIL cap_rst_addr: got %o want 0", mem_addr); else n_pass++;
    n_checks++; if (mem_din !== 12'o0000) $display("FAIL cap_rst_din: got %o want 0", mem_din); else n_pass++;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (mem[{3'd1, 12'o0300}] !== 12'o0005) $display("FAIL cap_rst_mem: got %o want 0005", mem[{3'd1, 12'o0300}]); else n_pass++;
    // Same op, reset raised during the write-back cycle
    req = 1'b1; op = T_ISZ; field = 3'd1; addr = 12'o0300;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++; if (mem_we !== 1'b0) $display("FAIL wr_rst_we: got %b want 0", mem_we); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (mem[{3'd1, 12'o0300}] !== 12'o0005) $display("FAIL wr_rst_mem: got %o want 0005", mem[{3'd1, 12'o0300}]); else n_pass++;
  endtask

  task automatic test_out_of_range();
    exp_q.push_back('{1'b1, 12'o0000, 1'b0, 3});
    run_op(T_READ, 3'd5, 12'o0100, 12'o0000, rd, sk, lat);
    e = exp_q.pop_front();
    n_checks++;
    if ({(e.chk_rd ? rd : e.rd), sk, lat} !== {e.rd, e.sk, e.lat})
      $display("FAIL oor_read: got rdata=%o skip=%b lat=%0d want rdata=%o skip=%b lat=%0d", rd, sk, lat, e.rd, e.sk, e.lat);
    else n_pass++;
    exp_q.push_back('{1'b0, 12'o0000, 1'b0, 2});
    run_op(T_WRITE, 3'd5, 12'o0100, 12'o1234, rd, sk, lat);
    e = exp_q.pop_front();
    n_checks++;
    if ({(e.chk_rd ? rd : e.rd), sk, lat} !== {e.rd, e.sk, e.lat})
      $display("FAIL oor_write: got rdata=%o skip=%b lat=%0d want rdata=%o skip=%b lat=%0d", rd, sk, lat, e.rd, e.sk, e.lat);
    else n_pass++;
    exp_q.push_back('{1'b1, 12'o0000, 1'b0, 3});
    run_op(T_READ, 3'd5, 12'o0100, 12'o0000, rd, sk, lat);
    e = exp_q.pop_front();
    n_checks++;
    if ({(e.chk_rd ? rd : e.rd), sk, lat} !== {e.rd, e.sk, e.lat})
      $display("FAIL oor_readback: got rdata=%o skip=%b lat=%0d want rdata=%o skip=%b lat=%0d", rd, sk, lat, e.rd, e.sk, e.lat);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset = 1'b1; req = 1'b0; op = 2'd0; field = 3'd0; addr = 12'o0000; wdata = 12'o0000;
    test_reset();
    test_write_read();
    test_isz();
    test_ind();
    test_back_to_back();
    test_reset_mid_op();
    test_out_of_range();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
